// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and constants for the count sequencer.
// Holds the FSM state encodings, the command codes produced by the edge
// arbiter, the 0..99 counter range and the terminal-value helper.
package count_seq_pkg;

    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = 7'd99;
    localparam logic [CNT_W-1:0] CNT_MIN = 7'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_t;

    // Up-counting treats anything at or beyond 99 as terminal so an
    // out-of-range feedback value never gets stepped further.
    function automatic logic at_terminal(input logic up, input logic [CNT_W-1:0] value);
        return up ? (value >= CNT_MAX) : (value == CNT_MIN);
    endfunction

endpackage

// File: rtl/count_seq_edge.sv
// count_seq_edge: registers a level request and emits a one-cycle pulse
// one cycle after each rising edge. The detector only arms after the
// request has been observed low, so a level held through reset release
// is not mistaken for a new command.
module count_seq_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic pulse
);

    logic req_p0;
    logic req_p1;
    logic armed;

    // Two-deep request history plus the "seen low since reset" flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_p0 <= 1'b0;
            req_p1 <= 1'b0;
            armed  <= 1'b0;
        end else begin
            req_p0 <= req;
            req_p1 <= req_p0;
            armed  <= armed | ~req;
        end
    end

    assign pulse = req_p0 & ~req_p1 & armed;

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: start/stop/load sequencer driving an external 0..99
// counter through one-cycle step and load strobes, paced by a prescaler
// that runs only in RUN.
// Optional build macro COUNT_SEQ_AUTOREVERSE_EN: a terminal tick flips the
// direction and keeps running (ping-pong) instead of entering DONE.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int LOAD_UP  = 90,
    parameter int LOAD_DN  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic             up_down,
    input  logic [CNT_W-1:0] count_in,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_o
);

    localparam int PRESC_W = 16;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   LOAD_UP_V  = CNT_W'(LOAD_UP);
    localparam logic [CNT_W-1:0]   LOAD_DN_V  = CNT_W'(LOAD_DN);

    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic               dir;
    logic               start_p;
    logic               stop_p;
    logic               load_p;
    cmd_t               cmd;
    logic               tick;

    count_seq_edge u_start_edge (.clk(clk), .rst_n(rst_n), .req(start), .pulse(start_p));
    count_seq_edge u_stop_edge  (.clk(clk), .rst_n(rst_n), .req(stop),  .pulse(stop_p));
    count_seq_edge u_load_edge  (.clk(clk), .rst_n(rst_n), .req(load),  .pulse(load_p));

    // Resolve coincident command edges: stop beats load beats start
    always_comb begin
        cmd = CMD_NONE;
        if (stop_p)       cmd = CMD_STOP;
        else if (load_p)  cmd = CMD_LOAD;
        else if (start_p) cmd = CMD_START;
    end

    assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

    function automatic logic [CNT_W-1:0] preload(input logic up);
        return up ? LOAD_UP_V : LOAD_DN_V;
    endfunction

    // Sequencer state, prescaler, latched direction and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            presc        <= '0;
            dir          <= 1'b1;
            cnt_en       <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
        end else begin
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            // Prescaler free-runs in RUN and is held at zero elsewhere, so
            // every entry into RUN starts a full TICK_DIV period.
            presc    <= (state == ST_RUN && !tick) ? presc + PRESC_W'(1) : '0;
            case (state)
                ST_IDLE: begin
                    if (cmd == CMD_START) begin
                        dir   <= up_down;
                        state <= ST_RUN;
                    end else if (cmd == CMD_LOAD) begin
                        dir          <= up_down;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= preload(up_down);
                    end
                end
                ST_RUN: begin
                    if (cmd == CMD_STOP) begin
                        state <= ST_PAUSE;
                    end else if (cmd == CMD_LOAD) begin
                        cnt_load     <= 1'b1;
                        cnt_load_val <= preload(dir);
                        state        <= ST_IDLE;
                    end else if (tick) begin
                        if (!at_terminal(dir, count_in)) begin
                            cnt_en <= 1'b1;
                        end else begin
`ifdef COUNT_SEQ_AUTOREVERSE_EN
                            dir <= ~dir;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cmd == CMD_STOP) begin
                        state <= ST_IDLE;
                    end else if (cmd == CMD_LOAD) begin
                        cnt_load     <= 1'b1;
                        cnt_load_val <= preload(dir);
                        state        <= ST_IDLE;
                    end else if (cmd == CMD_START) begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (cmd == CMD_STOP) begin
                        state <= ST_IDLE;
                    end else if (cmd == CMD_LOAD) begin
                        // Load from DONE behaves exactly as from IDLE and
                        // leaves the sequencer idle.
                        dir          <= up_down;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= preload(up_down);
                        state        <= ST_IDLE;
                    end else if (cmd == CMD_START) begin
                        // Restart from the opposite end of the range.
                        dir          <= up_down;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= up_down ? CNT_MIN : CNT_MAX;
                        state        <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cnt_up  = dir;
    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign state_o = state;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios pinned by literal
// expectations plus randomized stimulus checked every cycle against a
// behavioural model of the sequencer.
module tb_count_seq_ctrl;

    localparam int TDIV = 4;
    localparam int LU   = 90;
    localparam int LD   = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, load, up_down;
    logic [6:0] count_in;
    logic       cnt_en, cnt_up, cnt_load, busy, done;
    logic [6:0] cnt_load_val;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    count_seq_ctrl #(.TICK_DIV(TDIV), .LOAD_UP(LU), .LOAD_DN(LD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .up_down(up_down), .count_in(count_in), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .busy(busy),
        .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Command = request sampled high at the previous edge and low at the
    // one before; after reset the history counts as high so a held level
    // never forms an edge. run_age counts edges spent in RUN since entry.
    int       m_state = 0;
    bit       m_dir   = 1'b1;
    bit       m_en    = 1'b0;
    bit       m_ld    = 1'b0;
    int       m_val   = 0;
    int       run_age = 0;
    bit [2:0] m_s     = 3'b111;
    bit [2:0] m_sp    = 3'b111;

    always @(negedge rst_n) begin
        m_state = 0; m_dir = 1'b1; m_en = 1'b0; m_ld = 1'b0; m_val = 0;
        run_age = 0; m_s = 3'b111; m_sp = 3'b111;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit [2:0] rise;
            int       cmd, ns, ci;
            bit       tick, term;
            rise = m_s & ~m_sp;                       // {stop, load, start}
            cmd  = rise[2] ? 3 : rise[1] ? 2 : rise[0] ? 1 : 0;
            m_sp = m_s;
            m_s  = {stop, load, start};
            ci   = int'(count_in);
            m_en = 1'b0;
            m_ld = 1'b0;
            ns   = m_state;
            tick = (m_state == 1) && (run_age % TDIV == TDIV - 1);
            case (m_state)
                0: if (cmd == 1) begin m_dir = up_down; ns = 1; end
                   else if (cmd == 2) begin m_dir = up_down; m_ld = 1'b1; m_val = up_down ? LU : LD; end
                1: if (cmd == 3) ns = 2;
                   else if (cmd == 2) begin m_ld = 1'b1; m_val = m_dir ? LU : LD; ns = 0; end
                   else if (tick) begin
                       term = m_dir ? (ci >= 99) : (ci == 0);
                       if (!term) m_en = 1'b1;
                       else begin
`ifdef COUNT_SEQ_AUTOREVERSE_EN
                           m_dir = ~m_dir;
`else
                           ns = 3;
`endif
                       end
                   end
                2: if (cmd == 3) ns = 0;
                   else if (cmd == 2) begin m_ld = 1'b1; m_val = m_dir ? LU : LD; ns = 0; end
                   else if (cmd == 1) ns = 1;
                default: if (cmd == 3) ns = 0;
                   else if (cmd == 2) begin m_dir = up_down; m_ld = 1'b1; m_val = up_down ? LU : LD; ns = 0; end
                   else if (cmd == 1) begin m_dir = up_down; m_ld = 1'b1; m_val = up_down ? 0 : 99; ns = 1; end
            endcase
            if (ns == 1) run_age = (m_state == 1) ? run_age + 1 : 0;
            m_state = ns;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cnt_en",   32'(cnt_en),   32'(m_en));
        chk("cnt_load", 32'(cnt_load), 32'(m_ld));
        chk("state_o",  32'(state_o),  32'(m_state));
        chk("busy",     32'(busy),     32'(m_state == 1));
        chk("done",     32'(done),     32'(m_state == 3));
        if (m_en || !rst_n) chk("cnt_up", 32'(cnt_up), 32'(m_dir));
        if (m_ld || !rst_n) chk("cnt_load_val", 32'(cnt_load_val), 32'(m_val));
    end

    // Wait (bounded) for an output: 0 busy, 1 cnt_en, 2 done, 3 cnt_load
    task automatic wait_sig(input int which, input int budget, input string name);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = busy;
                1:       hit = cnt_en;
                2:       hit = done;
                default: hit = cnt_load;
            endcase
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL timeout_%s: not seen within %0d cycles, required once", name, budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t_busy, t1, t2;
        bit  ld_seen;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; up_down = 1'b1; count_in = 7'd5;
        repeat (3) @(negedge clk);
        chk("rst_cnt_en", 32'(cnt_en), 0);
        chk("rst_cnt_up", 32'(cnt_up), 1);
        chk("rst_cnt_load", 32'(cnt_load), 0);
        chk("rst_load_val", 32'(cnt_load_val), 0);
        chk("rst_state", 32'(state_o), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Start up, count_in=5: pulses every TDIV cycles, first TDIV after busy
        start = 1'b1; up_down = 1'b1;
        wait_sig(0, 10, "busy");
        t_busy = cyc;
        wait_sig(1, 20, "first_en");
        t1 = cyc;
        chk("first_en_delay", 32'(t1 - t_busy), 4);
        chk("first_en_up", 32'(cnt_up), 1);
        wait_sig(1, 20, "second_en");
        t2 = cyc;
        chk("en_period", 32'(t2 - t1), 4);
        chk("second_en_up", 32'(cnt_up), 1);

`ifndef COUNT_SEQ_AUTOREVERSE_EN
        // Terminal up tick -> DONE, then restart down loads 99
        count_in = 7'd99;
        wait_sig(2, 20, "done");
        chk("done_state", 32'(state_o), 3);
        chk("done_no_en", 32'(cnt_en), 0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; up_down = 1'b0;
        wait_sig(3, 10, "restart_load");
        chk("restart_val", 32'(cnt_load_val), 99);
        chk("restart_state", 32'(state_o), 1);
`else
        // Terminal up tick reverses direction and stays running
        count_in = 7'd99;
        wait_sig(1, 20, "reverse_en");
        chk("reverse_up", 32'(cnt_up), 0);
        chk("reverse_done", 32'(done), 0);
`endif

        // start, stop, load rising together in RUN -> PAUSE, no load
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; stop = 1'b1; load = 1'b1;
        ld_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ld_seen |= cnt_load;
        end
        chk("coincide_state", 32'(state_o), 2);
        chk("coincide_no_load", 32'(ld_seen), 0);

        // PAUSE --stop--> IDLE, then load down gives LD for one cycle
        start = 1'b0; stop = 1'b0; load = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        repeat (3) @(negedge clk);
        chk("pause_stop_state", 32'(state_o), 0);
        load = 1'b1; up_down = 1'b0;
        wait_sig(3, 10, "idle_load");
        chk("idle_load_val", 32'(cnt_load_val), 10);
        chk("idle_load_state", 32'(state_o), 0);
        @(negedge clk);
        chk("idle_load_width", 32'(cnt_load), 0);

        // Asynchronous reset two cycles into RUN with start held high
        stop = 1'b0; load = 1'b0;
        @(negedge clk);
        start = 1'b1; up_down = 1'b1;
        wait_sig(0, 10, "busy2");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_state", 32'(state_o), 0);
        chk("async_cnt_up", 32'(cnt_up), 1);
        chk("async_en", 32'(cnt_en), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_start_state", 32'(state_o), 0);
        chk("held_start_busy", 32'(busy), 0);
        start = 1'b0;

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)  start = ~start;
            if ($urandom_range(0, 15) == 0) stop  = ~stop;
            if ($urandom_range(0, 9) == 0)  load  = ~load;
            up_down = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       count_in = 7'd0;
                1:       count_in = 7'd99;
                2:       count_in = 7'($urandom_range(100, 127));
                default: count_in = 7'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
